// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: an 11-state FSM that sequences fetch,
// decode, memory, R-format, branch and jump steps, waits on a memory
// handshake, flags unsupported opcodes and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             data_read_flag,
  output logic             data_write_flag,
  output logic [1:0]       ALU_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write_flag,
  output logic             write_reg_mux_select,
  output logic             send_to_reg_select,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_JUMP = 6'b000010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;
  logic             retire;
  logic [5:0]       opcode;

  assign opcode      = instruction[31:26];
  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal_op  = illegal_q;

  // Next-state selection and detection of instruction-retiring transitions
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_JUMP:      state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE:   state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
      if (state_d == S_HALT) illegal_q <= 1'b1;
    end
  end

  // Control-signal decode from current state; strobes are forced low in reset
  always_comb begin
    pc_write             = 1'b0;
    pc_src               = 2'b00;
    ir_write             = 1'b0;
    i_or_d               = 1'b0;
    data_read_flag       = 1'b0;
    data_write_flag      = 1'b0;
    ALU_op               = 2'b00;
    alu_src_a            = 1'b0;
    alu_src_b            = 2'b00;
    reg_write_flag       = 1'b0;
    write_reg_mux_select = 1'b0;
    send_to_reg_select   = 1'b0;
    case (state_q)
      S_FETCH: begin
        data_read_flag = 1'b1;
        alu_src_b      = 2'b01;
        ir_write       = mem_ready;
        pc_write       = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        i_or_d         = 1'b1;
        data_read_flag = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d          = 1'b1;
        data_write_flag = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_flag     = 1'b1;
        send_to_reg_select = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        ALU_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write_flag       = 1'b1;
        write_reg_mux_select = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALU_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write        = 1'b0;
      ir_write        = 1'b0;
      data_read_flag  = 1'b0;
      data_write_flag = 1'b0;
      reg_write_flag  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (counter width 4 so wrap is reachable).
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instruction;
  logic          zero;
  logic          mem_ready;
  logic [3:0]    state;
  logic          pc_write;
  logic [1:0]    pc_src;
  logic          ir_write;
  logic          i_or_d;
  logic          data_read_flag;
  logic          data_write_flag;
  logic [1:0]    ALU_op;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic          reg_write_flag;
  logic          write_reg_mux_select;
  logic          send_to_reg_select;
  logic          illegal_op;
  logic [CW-1:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .state(state), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .i_or_d(i_or_d), .data_read_flag(data_read_flag),
    .data_write_flag(data_write_flag), .ALU_op(ALU_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write_flag(reg_write_flag),
    .write_reg_mux_select(write_reg_mux_select),
    .send_to_reg_select(send_to_reg_select), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op);
    instruction = {op, 26'h0};
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; instruction = '0;
    tick(); tick();
    // reset state and strobe gating while reset is high
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_rd_strobe", 32'(data_read_flag), 32'd0);
    chk("rst_irw_strobe", 32'(ir_write), 32'd0);

    // fetch stall: mem_ready low holds FETCH with read asserted
    reset = 1'b0; mem_ready = 1'b0; set_op(6'b100011);
    #1;
    chk("fstall_rd", 32'(data_read_flag), 32'd1);
    chk("fstall_irw", 32'(ir_write), 32'd0);
    chk("fstall_pcw", 32'(pc_write), 32'd0);
    tick();
    chk("fstall_state", 32'(state), 32'd0);

    // lw with mem_ready always 1: 0,1,2,3,4,0
    mem_ready = 1'b1; #1;
    chk("lw_f_irw", 32'(ir_write), 32'd1);
    chk("lw_f_pcw", 32'(pc_write), 32'd1);
    chk("lw_f_srcb", 32'(alu_src_b), 32'd1);
    tick(); chk("lw_s1", 32'(state), 32'd1);
    chk("lw_dec_srcb", 32'(alu_src_b), 32'd3);
    chk("lw_dec_regw", 32'(reg_write_flag), 32'd0);
    tick(); chk("lw_s2", 32'(state), 32'd2);
    chk("lw_ma_srcab", 32'({alu_src_a, alu_src_b, ALU_op}), 32'b1_10_00);
    tick(); chk("lw_s3", 32'(state), 32'd3);
    chk("lw_mr_iod_rd", 32'({i_or_d, data_read_flag, reg_write_flag}), 32'b110);
    tick(); chk("lw_s4", 32'(state), 32'd4);
    chk("lw_wb", 32'({reg_write_flag, send_to_reg_select, write_reg_mux_select}), 32'b110);
    tick(); chk("lw_s0", 32'(state), 32'd0);
    chk("lw_count", 32'(instr_count), 32'd1);
    chk("lw_f_regw", 32'(reg_write_flag), 32'd0);

    // sw with 3 wait cycles in MEM_WRITE
    set_op(6'b101011);
    tick(); tick(); tick();
    chk("sw_s5", 32'(state), 32'd5);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sw_wait%0d_wr", i), 32'({data_write_flag, i_or_d, reg_write_flag}), 32'b110);
      tick();
      chk($sformatf("sw_wait%0d_state", i), 32'(state), 32'd5);
    end
    mem_ready = 1'b1; #1;
    chk("sw_last_wr", 32'(data_write_flag), 32'd1);
    chk("sw_count_pre", 32'(instr_count), 32'd1);
    tick();
    chk("sw_s0", 32'(state), 32'd0);
    chk("sw_count", 32'(instr_count), 32'd2);

    // beq taken then not taken
    set_op(6'b000100); zero = 1'b1;
    tick(); tick();
    chk("beq1_s8", 32'(state), 32'd8);
    chk("beq1_ctl", 32'({pc_write, pc_src, ALU_op, alu_src_a, alu_src_b}), 32'b1_01_01_1_00);
    tick(); chk("beq1_count", 32'(instr_count), 32'd3);
    zero = 1'b0;
    tick(); tick();
    chk("beq2_s8", 32'(state), 32'd8);
    chk("beq2_pcw", 32'(pc_write), 32'd0);
    tick(); chk("beq2_count", 32'(instr_count), 32'd4);

    // jump
    set_op(6'b000010);
    tick(); tick();
    chk("j_s9", 32'(state), 32'd9);
    chk("j_ctl", 32'({pc_write, pc_src}), 32'b1_10);
    tick(); chk("j_count", 32'(instr_count), 32'd5);

    // illegal opcode: DECODE then HALT, held 10 cycles
    set_op(6'b111111);
    tick(); chk("ill_s1", 32'(state), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("halt%0d", i),
          32'({state, illegal_op, pc_write, ir_write, data_read_flag, data_write_flag, reg_write_flag}),
          32'({4'd10, 1'b1, 5'b00000}));
      tick();
    end
    chk("halt_count", 32'(instr_count), 32'd5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_illegal", 32'(illegal_op), 32'd0);
    chk("halt_rst_count", 32'(instr_count), 32'd0);

    // 16 R-format instructions: 0,1,6,7 each, counter wraps 15->0
    set_op(6'b000000);
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("r%0d_s0", n), 32'(state), 32'd0);
      tick(); chk($sformatf("r%0d_s1", n), 32'(state), 32'd1);
      tick(); chk($sformatf("r%0d_s6", n), 32'({state, ALU_op, alu_src_a, alu_src_b}), 32'({4'd6, 2'b10, 1'b1, 2'b00}));
      tick(); chk($sformatf("r%0d_s7", n), 32'({state, reg_write_flag, write_reg_mux_select, send_to_reg_select}), 32'({4'd7, 3'b110}));
      tick(); chk($sformatf("r%0d_count", n), 32'(instr_count), 32'((n + 1) % 16));
    end

    // reset during MEM_READ wait abandons lw without counting
    set_op(6'b100011);
    tick(); tick(); tick();
    chk("rmr_s3", 32'(state), 32'd3);
    mem_ready = 1'b0; reset = 1'b1; #1;
    chk("rmr_rd_gated", 32'({data_read_flag, reg_write_flag}), 32'b00);
    tick();
    reset = 1'b0;
    chk("rmr_state", 32'(state), 32'd0);
    chk("rmr_count", 32'(instr_count), 32'd0);
    chk("rmr_regw", 32'(reg_write_flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
